// File: rtl/fsm_seq_ctrl_if.sv
// Bundle between the pattern sequencer and its user / sequenced FSM.
// The master side is the sequencer itself.
interface fsm_seq_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [1:0]       target;
  logic [1:0]       fsm_o;
  logic             fsm_clk_en;
  logic             fsm_x;
  logic             fsm_rst;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    input  start, pattern, target, fsm_o,
    output fsm_clk_en, fsm_x, fsm_rst,
    output busy, done, hit_cnt
  );

  modport slave (
    output start, pattern, target, fsm_o,
    input  fsm_clk_en, fsm_x, fsm_rst,
    input  busy, done, hit_cnt
  );
endinterface

// File: rtl/fsm_seq_ctrl.sv
// Hardware sequencer: resets a Moore FSM, plays a pattern into x
// on prescaled ticks and counts ticks whose output matches target.
module fsm_seq_ctrl #(
  parameter int PAT_W = 8,
  parameter int DIV   = 4,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic reset,
  fsm_seq_ctrl_if.master bus
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(PAT_W + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [PAT_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic             pend_q, pend_d;
  logic             clk_en_q, clk_en_d;
  logic             x_q, x_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    hit_d   = hit_q;
    pend_d  = 1'b0;
    tick    = (state_q == S_RUN) && (pre_q == PRE_MAX);

    // FSM output has settled one cycle after its tick
    if (pend_q && (bus.fsm_o == bus.target) && (hit_q != CNT_MAX))
      hit_d = hit_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shift_d = bus.pattern;
          hit_d   = '0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        pre_d   = '0;
        bit_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        if (tick) begin
          shift_d = {shift_q[PAT_W-2:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          pend_d  = 1'b1;
          if (bit_q == BIT_LAST)
            state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    clk_en_d = (state_d == S_RUN) && (pre_d == PRE_MAX);
    x_d      = (state_d == S_RUN) && shift_d[PAT_W-1];
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      hit_q    <= '0;
      pend_q   <= 1'b0;
      clk_en_q <= 1'b0;
      x_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      hit_q    <= hit_d;
      pend_q   <= pend_d;
      clk_en_q <= clk_en_d;
      x_q      <= x_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.fsm_rst    = ~reset | (state_q == S_INIT);
  assign bus.fsm_clk_en = clk_en_q;
  assign bus.fsm_x      = x_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.hit_cnt    = hit_q;
endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Bench for fsm_seq_ctrl: three configurations against a
// timeline model of a run, plus directed literal checks.
module tb_fsm_seq_ctrl;
  localparam int DIVS [3] = '{4, 4, 1};
  localparam int CWS  [3] = '{4, 2, 4};

  logic       clk;
  int         cyc;
  int         checks;
  int         failures;
  logic       chk_on;

  logic       rn  [3];
  logic       st  [3];
  logic [7:0] pat [3];
  logic [1:0] tg  [3];

  logic       o_busy [3];
  logic       o_done [3];
  logic       o_en   [3];
  logic       o_x    [3];
  logic       o_rst  [3];
  logic [3:0] o_hc   [3];

  int         m_t    [3];
  logic [7:0] m_pat  [3];
  int         m_hits [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fsm_seq_ctrl_if #(.PAT_W(8), .CNT_W(CWS[g])) bus ();
    logic [1:0] stub_o;

    fsm_seq_ctrl #(
      .PAT_W(8),
      .DIV(DIVS[g]),
      .CNT_W(CWS[g])
    ) u_dut (
      .clk(clk),
      .reset(rn[g]),
      .bus(bus)
    );

    // Stand-in for the lab FSM: output follows x on each enabled edge
    always @(posedge clk) begin
      if (bus.fsm_rst) stub_o <= 2'b00;
      else if (bus.fsm_clk_en) stub_o <= {1'b0, bus.fsm_x};
    end

    assign bus.fsm_o   = stub_o;
    assign bus.start   = st[g];
    assign bus.pattern = pat[g];
    assign bus.target  = tg[g];
    assign o_busy[g]   = bus.busy;
    assign o_done[g]   = bus.done;
    assign o_en[g]     = bus.fsm_clk_en;
    assign o_x[g]      = bus.fsm_x;
    assign o_rst[g]    = bus.fsm_rst;
    assign o_hc[g]     = 4'(bus.hit_cnt);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: m_t is the cycle index within a run (1 = INIT), 0 when idle
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int d, last, k, maxc;
      d    = DIVS[i];
      last = 3 + 8 * d;
      maxc = (1 << CWS[i]) - 1;
      if (!rn[i]) begin
        m_t[i]    = 0;
        m_hits[i] = 0;
      end else if (m_t[i] == 0) begin
        if (st[i]) begin
          m_t[i]    = 1;
          m_pat[i]  = pat[i];
          m_hits[i] = 0;
        end
      end else begin
        if (m_t[i] >= 2 + d && m_t[i] <= 2 + 8 * d &&
            (m_t[i] - 2) % d == 0) begin
          k = (m_t[i] - 2) / d;
          if (tg[i] == {1'b0, m_pat[i][8-k]} && m_hits[i] < maxc)
            m_hits[i] = m_hits[i] + 1;
        end
        m_t[i] = (m_t[i] == last) ? 0 : m_t[i] + 1;
      end
    end
    chk_on <= 1'b1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        int d, t;
        logic e_en, e_x;
        d    = DIVS[i];
        t    = m_t[i];
        e_en = (t >= 1 + d) && (t <= 1 + 8 * d) && ((t - 1) % d == 0);
        e_x  = 1'b0;
        if (t >= 2 && t <= 1 + 8 * d) e_x = m_pat[i][7-(t-2)/d];
        chk($sformatf("u%0d.busy", i), 32'(o_busy[i]), 32'(t >= 1));
        chk($sformatf("u%0d.done", i), 32'(o_done[i]),
            32'(t == 3 + 8 * d));
        chk($sformatf("u%0d.fsm_rst", i), 32'(o_rst[i]),
            32'(!rn[i] || t == 1));
        chk($sformatf("u%0d.clk_en", i), 32'(o_en[i]), 32'(e_en));
        chk($sformatf("u%0d.fsm_x", i), 32'(o_x[i]), 32'(e_x));
        chk($sformatf("u%0d.hit_cnt", i), 32'(o_hc[i]), 32'(m_hits[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int s, rel;
  int nt0, f0, l0, nr0, r0, d0, nd0;
  int f2, l2, d2, nt2;
  logic [7:0] xs0;
  int d1, hd, r2, hr2, nd2;
  logic [7:0] p;

  initial begin
    checks   = 0;
    failures = 0;
    chk_on   = 1'b0;
    rn  = '{1'b0, 1'b0, 1'b0};
    st  = '{1'b1, 1'b1, 1'b1};
    pat = '{8'hB2, 8'hFF, 8'h0F};
    tg  = '{2'b01, 2'b01, 2'b00};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(o_busy[0]), 0);
    chk("rst.done", 32'(o_done[0]), 0);
    chk("rst.clk_en", 32'(o_en[0]), 0);
    chk("rst.fsm_x", 32'(o_x[0]), 0);
    chk("rst.fsm_rst", 32'(o_rst[0]), 1);
    chk("rst.hit_cnt", 32'(o_hc[0]), 0);
    step();
    rn = '{1'b1, 1'b1, 1'b1};
    st = '{1'b0, 1'b0, 1'b0};
    step();
    chk("rst.idle_busy", 32'(o_busy[0]), 0);

    // Nominal, saturation and DIV=1 runs side by side
    st = '{1'b1, 1'b1, 1'b1};
    s  = cyc;
    nt0 = 0; f0 = 0; l0 = 0; nr0 = 0; r0 = 0; d0 = 0; nd0 = 0;
    nt2 = 0; f2 = 0; l2 = 0; d2 = 0;
    xs0 = '0;
    step();
    st = '{1'b0, 1'b0, 1'b0};
    for (int c = 1; c <= 40; c++) begin
      if (c == 3) pat[0] = 8'h00;
      st[0] = (c == 10);
      @(negedge clk);
      rel = cyc - s;
      if (o_en[0]) begin
        nt0++;
        xs0 = {xs0[6:0], o_x[0]};
        if (f0 == 0) f0 = rel;
        l0 = rel;
      end
      if (o_rst[0]) begin nr0++; r0 = rel; end
      if (o_done[0]) begin nd0++; d0 = rel; end
      if (o_en[2]) begin
        nt2++;
        if (f2 == 0) f2 = rel;
        l2 = rel;
      end
      if (o_done[2]) d2 = rel;
      step();
    end
    chk("nom.first_tick", 32'(f0), 5);
    chk("nom.last_tick", 32'(l0), 33);
    chk("nom.ticks", 32'(nt0), 8);
    chk("nom.x_bits", 32'(xs0), 32'h B2);
    chk("nom.rst_cycles", 32'(nr0), 1);
    chk("nom.rst_cycle", 32'(r0), 1);
    chk("nom.done_cycle", 32'(d0), 35);
    chk("nom.done_count", 32'(nd0), 1);
    chk("nom.hit_cnt", 32'(o_hc[0]), 4);
    chk("sat.hit_cnt", 32'(o_hc[1]), 3);
    chk("div1.first_tick", 32'(f2), 2);
    chk("div1.last_tick", 32'(l2), 9);
    chk("div1.ticks", 32'(nt2), 8);
    chk("div1.done_cycle", 32'(d2), 11);
    chk("div1.hit_cnt", 32'(o_hc[2]), 4);

    // Back-to-back runs, then a reset in the middle of the second one
    p      = 8'($urandom);
    pat[0] = p;
    st[0]  = 1'b1;
    s      = cyc;
    d1 = 0; hd = 0; r2 = 0; hr2 = -1; nd2 = 0;
    step();
    for (int c = 1; c <= 90; c++) begin
      if (c == 38) st[0] = 1'b0;
      if (c == 51) rn[0] = 1'b0;
      if (c == 52) rn[0] = 1'b1;
      @(negedge clk);
      if (o_done[0] && c < 40) begin d1 = c; hd = o_hc[0]; end
      if (o_done[0] && c >= 40) nd2++;
      if (o_rst[0] && rn[0] && c > 1 && r2 == 0) begin
        r2  = c;
        hr2 = o_hc[0];
      end
      if (c == 51) chk("abort.fsm_rst", 32'(o_rst[0]), 1);
      if (c == 52) begin
        chk("abort.busy", 32'(o_busy[0]), 0);
        chk("abort.clk_en", 32'(o_en[0]), 0);
        chk("abort.hit_cnt", 32'(o_hc[0]), 0);
      end
      step();
    end
    chk("b2b.done_cycle", 32'(d1), 35);
    chk("b2b.hit_cnt", 32'(hd), 32'($countones(p)));
    chk("b2b.init_gap", 32'(r2 - d1), 2);
    chk("b2b.hit_cleared", 32'(hr2), 0);
    chk("abort.no_done", 32'(nd2), 0);

    // Randomised traffic on all three configurations
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++) begin
        st[i]  = ($urandom_range(0, 7) == 0);
        pat[i] = 8'($urandom);
        if ($urandom_range(0, 3) == 0) tg[i] = 2'($urandom);
        rn[i]  = ($urandom_range(0, 299) != 0);
      end
      step();
    end
    rn = '{1'b1, 1'b1, 1'b1};
    st = '{1'b0, 1'b0, 1'b0};
    repeat (50) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
